// File: rtl/eclair_useq_pkg.sv
`default_nettype none
// ============================================================================
// Package   : eclair_useq_pkg
// Purpose   : Shared definitions for the ECLair microcode sequencer:
//             sequencing opcodes, microword field offsets and FSM states.
// Revision  : 1.0 - initial release
// ============================================================================
package eclair_useq_pkg;

    // Microword sequencing field layout (low bits of every microword)
    localparam int SRC_BIT  = 0;
    localparam int OP_LSB   = 1;
    localparam int OP_W     = 3;
    localparam int CSEL_LSB = 4;

    // Sequencing opcodes; 3'b111 is reserved and behaves as NEXT
    localparam logic [OP_W-1:0] OP_NEXT  = 3'b000;
    localparam logic [OP_W-1:0] OP_JUMP  = 3'b001;
    localparam logic [OP_W-1:0] OP_CJMP  = 3'b010;
    localparam logic [OP_W-1:0] OP_CJMPN = 3'b011;
    localparam logic [OP_W-1:0] OP_CALL  = 3'b100;
    localparam logic [OP_W-1:0] OP_RET   = 3'b101;
    localparam logic [OP_W-1:0] OP_HALT  = 3'b110;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } useq_state_t;

    // Condition-select field width; kept at least one bit wide so a
    // single-flag configuration still has a legal field.
    function automatic int csel_width(input int cond_width);
        return (cond_width > 1) ? $clog2(cond_width) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/useq_stack.sv
`default_nettype none
// ============================================================================
// Module    : useq_stack
// Purpose   : Small LIFO holding microcode return addresses. Push is ignored
//             when full and pop is ignored when empty; the owner detects and
//             reports those faults itself.
// Revision  : 1.0 - initial release
// ============================================================================
module useq_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [2**IDX_W];
    logic [SP_W-1:0]  r_sp;
    logic [IDX_W-1:0] w_push_idx;
    logic [IDX_W-1:0] w_top_idx;
    logic             w_do_push;
    logic             w_do_pop;

    assign full       = (r_sp == SP_W'(DEPTH));
    assign empty      = (r_sp == '0);
    assign w_do_push  = push && !full;
    assign w_do_pop   = pop && !empty && !push;
    assign w_push_idx = IDX_W'(r_sp);
    assign w_top_idx  = IDX_W'(r_sp - SP_W'(1));
    assign dout       = r_mem[w_top_idx];

    // Stack pointer: counts live entries, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp <= '0;
        end else if (w_do_push) begin
            r_sp <= r_sp + SP_W'(1);
        end else if (w_do_pop) begin
            r_sp <= r_sp - SP_W'(1);
        end
    end

    // Entry storage; contents above the pointer are don't-care so no reset
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_push_idx] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/microcode_sequencer.sv
`default_nettype none
// ============================================================================
// Module    : microcode_sequencer
// Purpose   : ECLair control-store sequencer. Copies the microcode EPROM into
//             control-store RAM after reset, then sequences microwords with
//             conditional branches, call/return, stall and halt.
// Revision  : 1.0 - initial release
// ============================================================================
module microcode_sequencer
    import eclair_useq_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int WORD_WIDTH  = 64,
    parameter int COND_WIDTH  = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [WORD_WIDTH-1:0] rom_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [WORD_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    input  logic [WORD_WIDTH-1:0] ram_rdata,
    input  logic [COND_WIDTH-1:0] cond,
    input  logic [ADDR_WIDTH-1:0] ir_vec,
    input  logic                  stall,
    output logic [WORD_WIDTH-1:0] uinst,
    output logic                  uinst_valid,
    output logic [ADDR_WIDTH-1:0] upc,
    output logic                  ready,
    output logic                  halted,
    output logic                  stack_err
);

    localparam int CSEL_W     = csel_width(COND_WIDTH);
    localparam int LIT_LSB    = CSEL_LSB + CSEL_W;
    localparam int COND_EXT_W = 2**CSEL_W;

    useq_state_t           r_state;
    logic [ADDR_WIDTH-1:0] r_load_cnt;
    logic [ADDR_WIDTH-1:0] r_upc;
    logic                  r_ready;
    logic                  r_halted;
    logic                  r_stack_err;

    logic                  w_run;
    logic                  w_advance;
    logic [OP_W-1:0]       w_op;
    logic                  w_src;
    logic [CSEL_W-1:0]     w_sel;
    logic [ADDR_WIDTH-1:0] w_lit;
    logic [ADDR_WIDTH-1:0] w_target;
    logic [COND_EXT_W-1:0] w_cond_ext;
    logic                  w_cond_hit;
    logic [ADDR_WIDTH-1:0] w_upc_inc;
    logic [ADDR_WIDTH-1:0] w_next;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_fault;
    logic                  w_halt_op;
    logic                  w_stk_full;
    logic                  w_stk_empty;
    logic [ADDR_WIDTH-1:0] w_stk_dout;

    // Microword decode; only meaningful in RUN where ram_addr follows upc
    assign w_run      = (r_state == ST_RUN);
    assign w_advance  = w_run && !stall;
    assign w_op       = ram_rdata[OP_LSB +: OP_W];
    assign w_src      = ram_rdata[SRC_BIT];
    assign w_sel      = ram_rdata[CSEL_LSB +: CSEL_W];
    assign w_lit      = ram_rdata[LIT_LSB +: ADDR_WIDTH];
    assign w_target   = w_src ? w_lit : ir_vec;
    assign w_cond_ext = COND_EXT_W'(cond);
    assign w_cond_hit = w_cond_ext[w_sel];
    assign w_upc_inc  = r_upc + ADDR_WIDTH'(1);

    // Next-address selection and stack requests for the current microword
    always_comb begin
        w_next    = w_upc_inc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_fault   = 1'b0;
        w_halt_op = 1'b0;
        case (w_op)
            OP_JUMP:  w_next = w_target;
            OP_CJMP:  if (w_cond_hit)  w_next = w_target;
            OP_CJMPN: if (!w_cond_hit) w_next = w_target;
            OP_CALL: begin
                w_next = w_target;
                if (w_stk_full) w_fault = 1'b1;
                else            w_push  = w_advance;
            end
            OP_RET: begin
                w_next = w_stk_dout;
                if (w_stk_empty) w_fault = 1'b1;
                else             w_pop   = w_advance;
            end
            OP_HALT:  w_halt_op = 1'b1;
            default:  w_next = w_upc_inc;
        endcase
    end

    useq_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_WIDTH)
    ) u_stack (
        .clk   (clk),
        .rst   (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_upc_inc),
        .dout  (w_stk_dout),
        .full  (w_stk_full),
        .empty (w_stk_empty)
    );

    // Sequencer FSM: EPROM copy, microword sequencing, terminal halt
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_LOAD;
            r_load_cnt  <= '0;
            r_upc       <= '0;
            r_ready     <= 1'b0;
            r_halted    <= 1'b0;
            r_stack_err <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_load_cnt <= r_load_cnt + ADDR_WIDTH'(1);
                    if (r_load_cnt == '1) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                        r_upc   <= '0;
                    end
                end
                ST_RUN: begin
                    if (!stall) begin
                        if (w_halt_op) begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end else if (w_fault) begin
                            r_state     <= ST_HALT;
                            r_halted    <= 1'b1;
                            r_stack_err <= 1'b1;
                        end else begin
                            r_upc <= w_next;
                        end
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

    assign rom_addr    = r_load_cnt;
    assign ram_addr    = (r_state == ST_LOAD) ? r_load_cnt : r_upc;
    assign ram_wdata   = rom_data;
    assign ram_we      = (r_state == ST_LOAD);
    assign uinst       = w_run ? ram_rdata : '0;
    assign uinst_valid = w_run;
    assign upc         = r_upc;
    assign ready       = r_ready;
    assign halted      = r_halted;
    assign stack_err   = r_stack_err;

endmodule
`default_nettype wire

// File: tb/tb_microcode_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module    : tb_microcode_sequencer
// Purpose   : Self-checking bench for microcode_sequencer with EPROM/RAM
//             models and a behavioural sequencing reference.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_microcode_sequencer;

    localparam int AW = 8;
    localparam int WW = 64;
    localparam int CW = 4;
    localparam int SD = 4;

    localparam logic [2:0] T_NEXT  = 3'd0;
    localparam logic [2:0] T_JUMP  = 3'd1;
    localparam logic [2:0] T_CJMP  = 3'd2;
    localparam logic [2:0] T_CJMPN = 3'd3;
    localparam logic [2:0] T_CALL  = 3'd4;
    localparam logic [2:0] T_RET   = 3'd5;
    localparam logic [2:0] T_HALT  = 3'd6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] rom_addr;
    logic [WW-1:0] rom_data;
    logic [AW-1:0] ram_addr;
    logic [WW-1:0] ram_wdata;
    logic          ram_we;
    logic [WW-1:0] ram_rdata;
    logic [CW-1:0] cond = '0;
    logic [AW-1:0] ir_vec = '0;
    logic          stall = 1'b0;
    logic [WW-1:0] uinst;
    logic          uinst_valid;
    logic [AW-1:0] upc;
    logic          ready;
    logic          halted;
    logic          stack_err;

    logic [WW-1:0] rom [256];
    logic [WW-1:0] ram [256];

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural reference state: 0 = loading, 1 = running, 2 = halted
    logic [AW-1:0] m_upc;
    logic [AW-1:0] m_stack [$];
    int            m_state;
    logic          m_halted;
    logic          m_err;

    microcode_sequencer #(
        .ADDR_WIDTH  (AW),
        .WORD_WIDTH  (WW),
        .COND_WIDTH  (CW),
        .STACK_DEPTH (SD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_we      (ram_we),
        .ram_rdata   (ram_rdata),
        .cond        (cond),
        .ir_vec      (ir_vec),
        .stall       (stall),
        .uinst       (uinst),
        .uinst_valid (uinst_valid),
        .upc         (upc),
        .ready       (ready),
        .halted      (halted),
        .stack_err   (stack_err)
    );

    always #5 clk = ~clk;

    assign rom_data  = rom[rom_addr];
    assign ram_rdata = ram[ram_addr];

    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [WW-1:0] mk(input logic [2:0] op, input logic src,
                                         input logic [1:0] sel, input logic [7:0] lit);
        logic [WW-1:0] w;
        w = '0;
        w[0]    = src;
        w[3:1]  = op;
        w[5:4]  = sel;
        w[13:6] = lit;
        return w;
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = '0;
    endtask

    // Reference: advance one clock given the inputs present at that edge
    task automatic model_step(input logic st, input logic [3:0] c, input logic [7:0] iv);
        logic [WW-1:0] w;
        logic [7:0]    tgt;
        logic [7:0]    inc;
        logic [1:0]    sel;
        logic          hit;
        if (m_state != 1 || st) return;
        w   = rom[m_upc];
        tgt = w[0] ? w[13:6] : iv;
        inc = m_upc + 8'd1;
        sel = w[5:4];
        hit = c[sel];
        case (w[3:1])
            T_JUMP:  m_upc = tgt;
            T_CJMP:  m_upc = hit ? tgt : inc;
            T_CJMPN: m_upc = hit ? inc : tgt;
            T_CALL: begin
                if (m_stack.size() >= SD) begin
                    m_err = 1'b1; m_halted = 1'b1; m_state = 2;
                end else begin
                    m_stack.push_back(inc);
                    m_upc = tgt;
                end
            end
            T_RET: begin
                if (m_stack.size() == 0) begin
                    m_err = 1'b1; m_halted = 1'b1; m_state = 2;
                end else begin
                    m_upc = m_stack.pop_back();
                end
            end
            T_HALT: begin
                m_halted = 1'b1; m_state = 2;
            end
            default: m_upc = inc;
        endcase
    endtask

    task automatic tick(input logic st, input logic [3:0] c, input logic [7:0] iv);
        stall  = st;
        cond   = c;
        ir_vec = iv;
        model_step(st, c, iv);
        @(posedge clk);
        #1;
    endtask

    // Pulse reset and wait (bounded) for the control-store copy to complete
    task automatic do_reset();
        stall = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 300 && ready !== 1'b1; k++) begin
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (ready !== 1'b1) begin
            n_bad++;
            $display("FAIL load_done: ready=%b required 1 within 300 cycles", ready);
        end
        m_upc = '0;
        m_stack.delete();
        m_state  = 1;
        m_halted = 1'b0;
        m_err    = 1'b0;
    endtask

    task automatic test_reset_and_load();
        int bad_copy;
        for (int i = 0; i < 256; i++) rom[i] = WW'(i);
        stall = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (upc !== 8'h00 || ready !== 1'b0 || halted !== 1'b0 || stack_err !== 1'b0 ||
            uinst_valid !== 1'b0 || uinst !== '0) begin
            n_bad++;
            $display("FAIL reset_state: upc=%h ready=%b halted=%b err=%b valid=%b uinst=%h required 00/0/0/0/0/0",
                     upc, ready, halted, stack_err, uinst_valid, uinst);
        end
        reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            stall = 1'($urandom_range(0, 1));
            n_cmp++;
            if (ram_we !== 1'b1 || ram_addr !== 8'(i) || rom_addr !== 8'(i) ||
                ram_wdata !== WW'(i) || ready !== 1'b0 || uinst_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL load_cycle %0d: we=%b ram_addr=%h rom_addr=%h wdata=%h ready=%b required we=1 addr=%h wdata=%h ready=0",
                         i, ram_we, ram_addr, rom_addr, ram_wdata, ready, 8'(i), WW'(i));
            end
            @(posedge clk);
            #1;
        end
        stall = 1'b1;
        n_cmp++;
        if (ready !== 1'b1 || ram_we !== 1'b0 || upc !== 8'h00 || uinst_valid !== 1'b1 ||
            uinst !== rom[0] || halted !== 1'b0) begin
            n_bad++;
            $display("FAIL first_fetch: ready=%b we=%b upc=%h valid=%b uinst=%h required 1/0/00/1/%h",
                     ready, ram_we, upc, uinst_valid, uinst, rom[0]);
        end
        bad_copy = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== rom[i]) bad_copy++;
        n_cmp++;
        if (bad_copy != 0) begin
            n_bad++;
            $display("FAIL ram_copy: %0d words differ, required 0", bad_copy);
        end
        stall = 1'b0;
    endtask

    task automatic test_jump();
        clear_rom();
        rom[8'h00] = mk(T_JUMP, 1'b1, 2'd0, 8'h40);
        rom[8'h40] = mk(T_JUMP, 1'b0, 2'd0, 8'h99);
        do_reset();
        tick(1'b0, 4'($urandom), 8'($urandom));
        n_cmp++;
        if (upc !== 8'h40) begin
            n_bad++;
            $display("FAIL jump_literal: upc=%h required 40", upc);
        end
        tick(1'b0, 4'($urandom), 8'h23);
        n_cmp++;
        if (upc !== 8'h23 || uinst !== rom[8'h23]) begin
            n_bad++;
            $display("FAIL jump_irvec: upc=%h uinst=%h required 23 / %h", upc, uinst, rom[8'h23]);
        end
    endtask

    task automatic test_cond_branch();
        logic [7:0] c_entry [7] = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h20, 8'h20, 8'h20};
        logic [3:0] c_cond  [7] = '{4'b0100, 4'b0000, 4'b1011, 4'b1111, 4'b0100, 4'b0000, 4'b1011};
        logic [7:0] c_exp   [7] = '{8'h80, 8'h11, 8'h11, 8'h80, 8'h21, 8'h80, 8'h80};
        clear_rom();
        rom[8'h00] = mk(T_JUMP,  1'b0, 2'd0, 8'h00);
        rom[8'h10] = mk(T_CJMP,  1'b1, 2'd2, 8'h80);
        rom[8'h20] = mk(T_CJMPN, 1'b1, 2'd2, 8'h80);
        rom[8'h11] = mk(T_JUMP,  1'b0, 2'd0, 8'h00);
        rom[8'h21] = mk(T_JUMP,  1'b0, 2'd0, 8'h00);
        rom[8'h80] = mk(T_JUMP,  1'b0, 2'd0, 8'h00);
        do_reset();
        for (int i = 0; i < 7; i++) begin
            tick(1'b0, 4'($urandom), c_entry[i]);
            tick(1'b0, c_cond[i], 8'($urandom));
            n_cmp++;
            if (upc !== c_exp[i]) begin
                n_bad++;
                $display("FAIL cond_branch[%0d] at %h cond=%b: upc=%h required %h",
                         i, c_entry[i], c_cond[i], upc, c_exp[i]);
            end
        end
    endtask

    task automatic test_nested_calls(input logic overflow);
        logic [7:0] c_seq [9] = '{8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h51, 8'h41, 8'h31, 8'h21};
        logic [7:0] frozen;
        int         steps;
        clear_rom();
        rom[8'h00] = mk(T_JUMP, 1'b1, 2'd0, 8'h20);
        rom[8'h20] = mk(T_CALL, 1'b1, 2'd0, 8'h30);
        rom[8'h30] = mk(T_CALL, 1'b1, 2'd0, 8'h40);
        rom[8'h40] = mk(T_CALL, 1'b1, 2'd0, 8'h50);
        rom[8'h50] = mk(T_CALL, 1'b1, 2'd0, 8'h60);
        rom[8'h60] = overflow ? mk(T_CALL, 1'b1, 2'd0, 8'h70) : mk(T_RET, 1'b1, 2'd0, 8'h00);
        rom[8'h51] = mk(T_RET, 1'b1, 2'd0, 8'h00);
        rom[8'h41] = mk(T_RET, 1'b1, 2'd0, 8'h00);
        rom[8'h31] = mk(T_RET, 1'b1, 2'd0, 8'h00);
        rom[8'h21] = mk(T_RET, 1'b1, 2'd0, 8'h00);
        do_reset();
        steps  = overflow ? 5 : 9;
        frozen = c_seq[steps-1];
        for (int i = 0; i < steps; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                tick(1'b1, 4'($urandom), 8'($urandom));
                n_cmp++;
                if (upc !== (i == 0 ? 8'h00 : c_seq[i-1])) begin
                    n_bad++;
                    $display("FAIL call_stall[%0d]: upc=%h required %h", i, upc,
                             (i == 0 ? 8'h00 : c_seq[i-1]));
                end
            end
            tick(1'b0, 4'($urandom), 8'($urandom));
            n_cmp++;
            if (upc !== c_seq[i] || halted !== 1'b0) begin
                n_bad++;
                $display("FAIL call_seq[%0d]: upc=%h halted=%b required %h / 0", i, upc, halted, c_seq[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 4'($urandom), 8'($urandom));
            n_cmp++;
            if (halted !== 1'b1 || stack_err !== 1'b1 || upc !== frozen || uinst_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL stack_fault[%0d] ovf=%b: halted=%b err=%b upc=%h valid=%b required 1/1/%h/0",
                         i, overflow, halted, stack_err, upc, uinst_valid, frozen);
            end
        end
    endtask

    task automatic test_stall_wrap_halt();
        clear_rom();
        rom[8'h00] = mk(T_JUMP, 1'b0, 2'd0, 8'h00);
        rom[8'h05] = mk(T_CALL, 1'b1, 2'd0, 8'hFF);
        rom[8'h07] = mk(T_RET,  1'b1, 2'd0, 8'h00);
        rom[8'h06] = mk(T_RET,  1'b1, 2'd0, 8'h00);
        do_reset();
        tick(1'b0, 4'($urandom), 8'h05);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 4'($urandom), 8'($urandom));
            n_cmp++;
            if (upc !== 8'h05 || uinst_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: upc=%h valid=%b required 05 / 1", i, upc, uinst_valid);
            end
        end
        tick(1'b0, 4'($urandom), 8'($urandom));
        tick(1'b0, 4'($urandom), 8'($urandom));
        n_cmp++;
        if (upc !== 8'h00) begin
            n_bad++;
            $display("FAIL wrap: upc=%h required 00", upc);
        end
        tick(1'b0, 4'($urandom), 8'h07);
        tick(1'b0, 4'($urandom), 8'($urandom));
        tick(1'b0, 4'($urandom), 8'($urandom));
        n_cmp++;
        if (halted !== 1'b1 || stack_err !== 1'b1 || upc !== 8'h06) begin
            n_bad++;
            $display("FAIL stalled_call_single_push: halted=%b err=%b upc=%h required 1/1/06",
                     halted, stack_err, upc);
        end

        clear_rom();
        rom[8'h00] = mk(T_JUMP, 1'b1, 2'd0, 8'hFE);
        rom[8'hFE] = mk(T_HALT, 1'b1, 2'd0, 8'h00);
        do_reset();
        n_cmp++;
        if (halted !== 1'b0 || stack_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_clears_flags: halted=%b err=%b required 0/0", halted, stack_err);
        end
        tick(1'b0, 4'($urandom), 8'($urandom));
        tick(1'b1, 4'($urandom), 8'($urandom));
        n_cmp++;
        if (upc !== 8'hFE || halted !== 1'b0 || uinst_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL halt_stalled: upc=%h halted=%b valid=%b required FE/0/1", upc, halted, uinst_valid);
        end
        tick(1'b0, 4'($urandom), 8'($urandom));
        tick(1'b0, 4'($urandom), 8'($urandom));
        n_cmp++;
        if (upc !== 8'hFE || halted !== 1'b1 || uinst_valid !== 1'b0 || stack_err !== 1'b0 || uinst !== '0) begin
            n_bad++;
            $display("FAIL halt_op: upc=%h halted=%b valid=%b err=%b uinst=%h required FE/1/0/0/0",
                     upc, halted, uinst_valid, stack_err, uinst);
        end
    endtask

    task automatic test_midrun_reset();
        clear_rom();
        rom[8'h00] = mk(T_JUMP, 1'b0, 2'd0, 8'h00);
        rom[8'h10] = mk(T_CALL, 1'b1, 2'd0, 8'h11);
        rom[8'h30] = mk(T_RET,  1'b1, 2'd0, 8'h00);
        do_reset();
        tick(1'b0, 4'($urandom), 8'h10);
        tick(1'b0, 4'($urandom), 8'($urandom));
        tick(1'b0, 4'($urandom), 8'($urandom));
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (ready !== 1'b0 || ram_we !== 1'b1 || ram_addr !== 8'h00 || upc !== 8'h00 || uinst_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midrun_reset: ready=%b we=%b addr=%h upc=%h valid=%b required 0/1/00/00/0",
                     ready, ram_we, ram_addr, upc, uinst_valid);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (ram_addr !== 8'h01 || ram_we !== 1'b1) begin
            n_bad++;
            $display("FAIL reload_progress: addr=%h we=%b required 01 / 1", ram_addr, ram_we);
        end
        do_reset();
        tick(1'b0, 4'($urandom), 8'h30);
        tick(1'b0, 4'($urandom), 8'($urandom));
        n_cmp++;
        if (halted !== 1'b1 || stack_err !== 1'b1 || upc !== 8'h30) begin
            n_bad++;
            $display("FAIL stack_cleared_by_reset: halted=%b err=%b upc=%h required 1/1/30",
                     halted, stack_err, upc);
        end
    endtask

    task automatic test_random();
        int         r;
        logic [WW-1:0] w;
        logic [WW-1:0] exp_uinst;
        for (int round = 0; round < 4; round++) begin
            for (int i = 0; i < 256; i++) begin
                w = {$urandom, $urandom};
                r = $urandom_range(0, 39);
                if      (r == 0)  w[3:1] = T_HALT;
                else if (r < 7)   w[3:1] = T_RET;
                else if (r < 13)  w[3:1] = T_CALL;
                else if (r < 19)  w[3:1] = T_CJMP;
                else if (r < 25)  w[3:1] = T_CJMPN;
                else if (r < 30)  w[3:1] = T_JUMP;
                else if (r < 32)  w[3:1] = 3'b111;
                else              w[3:1] = T_NEXT;
                rom[i] = w;
            end
            do_reset();
            for (int cyc = 0; cyc < 150; cyc++) begin
                tick(($urandom_range(0, 3) == 0), 4'($urandom), 8'($urandom));
                exp_uinst = (m_state == 1) ? rom[m_upc] : '0;
                n_cmp++;
                if (upc !== m_upc || halted !== m_halted || stack_err !== m_err ||
                    uinst_valid !== (m_state == 1) || uinst !== exp_uinst) begin
                    n_bad++;
                    $display("FAIL random r%0d c%0d: upc=%h halted=%b err=%b valid=%b uinst=%h required %h/%b/%b/%b/%h",
                             round, cyc, upc, halted, stack_err, uinst_valid, uinst,
                             m_upc, m_halted, m_err, (m_state == 1), exp_uinst);
                end
            end
        end
    endtask

    initial begin
        test_reset_and_load();
        test_jump();
        test_cond_branch();
        test_nested_calls(1'b0);
        test_nested_calls(1'b1);
        test_stall_wrap_halt();
        test_midrun_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
Parametrised control-store sequencer for the ECLair CPU. It replaces the fixed 8-bit counter, ROM-to-RAM copier and halt-address decode with one block. At startup it copies the microcode EPROM into control-store RAM under its own FSM, then sequences microwords. Sequencing adds conditional branches, a call/return stack, stall and a halt microinstruction. It sits between the microcode EPROM/RAM and the datapath decode logic.

Parameters:
ADDR_WIDTH, 8, control-store address width; depth is 2**ADDR_WIDTH.
WORD_WIDTH, 64, microword width; must be ≥ 4+CSEL_W+ADDR_WIDTH.
COND_WIDTH, 4, number of condition-flag inputs; CSEL_W = $clog2(COND_WIDTH).
STACK_DEPTH, 4, return-address stack entries (≥1).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rom_addr  out  ADDR_WIDTH  EPROM read address
rom_data  in  WORD_WIDTH  EPROM data; combinational read
ram_addr  out  ADDR_WIDTH  control-store RAM address
ram_wdata  out  WORD_WIDTH  RAM write data
ram_we  out  1  RAM write enable; active high, written on clk rise
ram_rdata  in  WORD_WIDTH  RAM read data; combinational from ram_addr
cond  in  COND_WIDTH  datapath condition flags
ir_vec  in  ADDR_WIDTH  dispatch target taken from IR
stall  in  1  hold the current microword
uinst  out  WORD_WIDTH  current microword to the datapath
uinst_valid  out  1  uinst is live (RUN state only)
upc  out  ADDR_WIDTH  microprogram counter
ready  out  1  control store loaded
halted  out  1  HALT executed or stack fault
stack_err  out  1  sticky overflow/underflow flag

Behaviour:
- Microword sequencing fields:
  - bit0 SRC: target select; 0 = ir_vec, 1 = literal.
  - bits[3:1] OP: 000 NEXT, 001 JUMP, 010 CJMP (jump if cond[sel]=1), 011 CJMPN (jump if cond[sel]=0), 100 CALL, 101 RET, 110 HALT, 111 treated as NEXT.
  - bits[4+:CSEL_W] condition select.
  - bits[4+CSEL_W+:ADDR_WIDTH] literal target.
- States: LOAD, RUN, HALT. Reset forces LOAD.
- Reset values: load_cnt=0, upc=0, stack pointer=0, ready=0, halted=0, stack_err=0, uinst_valid=0, uinst=0.
- LOAD:
  - rom_addr = ram_addr = load_cnt; ram_wdata = rom_data; ram_we = 1.
  - load_cnt increments every cycle.
  - After the cycle writing address 2**ADDR_WIDTH−1: go to RUN, ready=1, upc=0, ram_we=0.
  - Load takes exactly 2**ADDR_WIDTH cycles; stall is ignored.
- RUN:
  - ram_addr = upc; uinst = ram_rdata; uinst_valid = 1.
  - Each clk with stall=0, upc <= next. With stall=1, upc, stack and state hold.
- next address:
  - NEXT = upc+1, wrapping mod 2**ADDR_WIDTH.
  - JUMP = target.
  - CJMP/CJMPN = target if the condition is met, else upc+1.
  - CALL pushes upc+1, then goes to target.
  - RET pops and goes to the popped address.
- HALT op: transition to HALT; halted=1, uinst_valid=0, upc frozen at the HALT word address. HALT exits only via reset.
- Stack faults:
  - CALL with STACK_DEPTH entries already used → stack_err=1, HALT, no push.
  - RET on empty stack → stack_err=1, HALT.
  - A stalled CALL/RET does not touch the stack.
- ready, once set, stays 1 until reset.
- Reset mid-LOAD or mid-RUN restarts LOAD from address 0 and clears the stack and all flags on the next edge.
- Outputs in RUN are combinational from upc/ram_rdata. State changes only on clk rise.

Decomposition:
- Package eclair_useq_pkg holds:
  - OP codes (OP_NEXT…OP_HALT).
  - State enum (ST_LOAD/ST_RUN/ST_HALT).
  - Field bit-offset constants SRC_BIT, OP_LSB, CSEL_LSB.
- One sub-module: useq_stack (parametrised LIFO). Ports: push, pop, din, dout, full, empty; synchronous reset.

Test Plan:
- Load and first fetch: reset pulse, ROM word[i]=i. Expect ram_we=1 for 256 cycles with ram_addr 0..255 and ram_wdata=i; ready rises after cycle 256; upc=0; uinst_valid=1.
- Literal JUMP: word0 = JUMP SRC=1 literal 0x40. Expect upc 0→0x40 in one cycle. A second test with SRC=0 and ir_vec=0x23 expects 0x23.
- Conditional branch at 0x10 (CJMP, sel=2, target 0x80):
  - cond=4'b0100 → upc=0x80.
  - cond=4'b0000 → upc=0x11.
  - CJMPN gives the inverse results.
- Nested calls: CALL 0x20→0x30→0x40→0x50 (depth 4), then RETs. Expect returns to 0x51, 0x41, 0x31, 0x21 in order.
- Stack faults: a fifth nested CALL gives halted=1, stack_err=1, upc frozen. A RET on an empty stack also halts.
- Stall, wrap, halt, mid-run reset:
  - stall=1 for 3 cycles at upc=0x05 holds upc=0x05.
  - NEXT at 0xFF wraps upc to 0x00.
  - HALT at 0xFE gives halted=1, uinst_valid=0.
  - reset mid-RUN gives ready=0 and load restarting at address 0.
